// File: rtl/div_arb_pkg.sv
// Shared types and default sizing for the two-requester divider arbiter.
package div_arb_pkg;

  localparam int DEFAULT_WIDTH   = 16;
  localparam int DEFAULT_TIMEOUT = 40;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } state_e;

endpackage

// File: rtl/div_arbiter_rr_arb2.sv
// Two-way round-robin grant: a lone request wins, a tie goes to the one not served last.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant,
  output logic       grant_id
);

  assign grant_id = (&req) ? ~last : req[1];
  assign grant    = {req[1] & grant_id, req[0] & ~grant_id};

endmodule

// File: rtl/div_arbiter.sv
// Shares one sequential divider between two requesters, with divide-by-zero
// bypass and a watchdog on the divider's completion strobe.
module div_arbiter
  import div_arb_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_dividend,
  input  logic [WIDTH-1:0] req0_divisor,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_dividend,
  input  logic [WIDTH-1:0] req1_divisor,
  output logic             req1_ready,
  output logic             resp0_valid,
  output logic [WIDTH-1:0] resp0_quot,
  output logic [WIDTH-1:0] resp0_rem,
  output logic             resp0_err,
  output logic             resp1_valid,
  output logic [WIDTH-1:0] resp1_quot,
  output logic [WIDTH-1:0] resp1_rem,
  output logic             resp1_err,
  output logic             div_start,
  output logic [WIDTH-1:0] div_dividend,
  output logic [WIDTH-1:0] div_divisor,
  input  logic             div_done,
  input  logic [WIDTH-1:0] div_quot,
  input  logic [WIDTH-1:0] div_rem,
  output logic             busy,
  output logic             grant_id
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [WIDTH-1:0]        dividend_q, dividend_d;
  logic [WIDTH-1:0]        divisor_q, divisor_d;
  logic                    gid_q, gid_d;
  logic                    last_q, last_d;
  logic [1:0][WIDTH-1:0]   quot_q, quot_d;
  logic [1:0][WIDTH-1:0]   rem_q, rem_d;
  logic [1:0]              err_q, err_d;

  logic [1:0]              grant;
  logic                    arb_id;
  logic [WIDTH-1:0]        sel_dividend;
  logic [WIDTH-1:0]        sel_divisor;

  rr_arb2 u_arb (
    .req      ({req1_valid, req0_valid}),
    .last     (last_q),
    .grant    (grant),
    .grant_id (arb_id)
  );

  assign sel_dividend = arb_id ? req1_dividend : req0_dividend;
  assign sel_divisor  = arb_id ? req1_divisor  : req0_divisor;

  // Per-requester result registers are written on the way into RESP so they
  // are already valid during the strobe and persist until that requester's next result.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dividend_d  = dividend_q;
    divisor_d   = divisor_q;
    gid_d       = gid_q;
    last_d      = last_q;
    quot_d      = quot_q;
    rem_d       = rem_q;
    err_d       = err_q;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    div_start   = 1'b0;
    resp0_valid = 1'b0;
    resp1_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if ((|grant) && rst) begin
          req0_ready = grant[0];
          req1_ready = grant[1];
          gid_d      = arb_id;
          dividend_d = sel_dividend;
          divisor_d  = sel_divisor;
          if (sel_divisor == '0) begin
            quot_d[arb_id] = '1;
            rem_d[arb_id]  = sel_dividend;
            err_d[arb_id]  = 1'b1;
            state_d        = ST_RESP;
          end else begin
            state_d = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        div_start = 1'b1;
        cnt_d     = '0;
        state_d   = ST_WAIT;
      end
      ST_WAIT: begin
        if (div_done) begin
          quot_d[gid_q] = div_quot;
          rem_d[gid_q]  = div_rem;
          err_d[gid_q]  = 1'b0;
          state_d       = ST_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == CNT_W'(TIMEOUT)) begin
            quot_d[gid_q] = '0;
            rem_d[gid_q]  = '0;
            err_d[gid_q]  = 1'b1;
            state_d       = ST_RESP;
          end
        end
      end
      ST_RESP: begin
        resp0_valid = ~gid_q;
        resp1_valid = gid_q;
        last_d      = gid_q;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // last_q resets to 1 so the first tie goes to requester 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      dividend_q <= '0;
      divisor_q  <= '0;
      gid_q      <= 1'b0;
      last_q     <= 1'b1;
      quot_q     <= '0;
      rem_q      <= '0;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      gid_q      <= gid_d;
      last_q     <= last_d;
      quot_q     <= quot_d;
      rem_q      <= rem_d;
      err_q      <= err_d;
    end
  end

  assign div_dividend = dividend_q;
  assign div_divisor  = divisor_q;
  assign resp0_quot   = quot_q[0];
  assign resp0_rem    = rem_q[0];
  assign resp0_err    = err_q[0];
  assign resp1_quot   = quot_q[1];
  assign resp1_rem    = rem_q[1];
  assign resp1_err    = err_q[1];
  assign busy         = (state_q != ST_IDLE);
  assign grant_id     = gid_q;

endmodule

// File: doc/div_arbiter.md
DIV_ARBITER -- requirements
Module: div_arbiter

Interface
REQ-001 Parameter WIDTH, default 16, SHALL set the operand/result width.
REQ-002 Parameter TIMEOUT, default 40, SHALL set the max cycles allowed from div_start to div_done.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 reqN_valid  input  1  requester N (N=0,1) has an operand pair pending.
REQ-006 reqN_dividend / reqN_divisor  input  WIDTH each  operands of requester N.
REQ-007 reqN_ready  output  1  accept strobe; a transfer occurs when valid and ready are both high.
REQ-008 respN_valid  output  1  one-cycle result strobe to requester N.
REQ-009 respN_quot / respN_rem  output  WIDTH each  result to requester N, held until the next response to N.
REQ-010 respN_err  output  1  divide-by-zero or timeout flag, qualified by respN_valid.
REQ-011 div_start  output  1  one-cycle start pulse to the shared sequential divider.
REQ-012 div_dividend / div_divisor  output  WIDTH each  latched operands, stable from div_start until div_done.
REQ-013 div_done  input  1  divider completion strobe.
REQ-014 div_quot / div_rem  input  WIDTH each  divider results, valid with div_done.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 grant_id  output  1  index of the requester currently being served.

Function
REQ-017 The FSM SHALL have states IDLE, ISSUE, WAIT and RESP.
REQ-018 IDLE: if any reqN_valid is high, assert reqN_ready for exactly the granted N, latch its operands and grant_id, then go to ISSUE (divisor != 0) or RESP (divisor == 0).
REQ-019 Arbitration SHALL be round-robin: a single requester is granted; with both valid, the one not served last is granted; the pointer after reset favours requester 0.
REQ-020 ISSUE: assert div_start for one cycle, clear the timeout counter, go to WAIT.
REQ-021 WAIT: on div_done, capture div_quot/div_rem and go to RESP; otherwise increment the counter, and when it reaches TIMEOUT go to RESP with err=1, quot=0, rem=0.
REQ-022 Divide-by-zero SHALL bypass the divider (no div_start) and return quot=all ones, rem=dividend, err=1.
REQ-023 RESP: pulse respN_valid for grant_id for one cycle, update the last-served pointer, return to IDLE.
REQ-024 div_done outside WAIT SHALL be ignored.
REQ-025 At most one reqN_ready SHALL be high in any cycle, and never outside IDLE.
REQ-026 Latency SHALL be: accept (cycle 0), div_start (cycle 1), resp_valid one cycle after div_done; divide-by-zero resp_valid at cycle 1.
REQ-027 A requester may hold valid through its own response; back-to-back requests SHALL be accepted in the IDLE cycle following RESP.

Reset
REQ-028 While rst is low: state=IDLE; all ready, resp_valid, resp_err, div_start and busy = 0; all data outputs = 0; grant_id = 0; pointer favours requester 0.
REQ-029 Reset asserted mid-operation SHALL abort without a response; divider results arriving after reset release SHALL be ignored.

Structure
REQ-030 Package div_arb_pkg SHALL hold the FSM state enum and the WIDTH/TIMEOUT defaults.
REQ-031 Round-robin grant logic SHALL be a sub-module rr_arb2 (req[1:0], last, grant, grant_id).

Verification
REQ-032 req0 50000/7, divider done after 17 cycles -> resp0_valid with quot=7142, rem=6, err=0; div_start pulsed exactly once.
REQ-033 req0 and req1 both valid with pairs 100/3 and 9/4 -> req0 served first (33,1), then req1 (2,1); grant_id 0 then 1.
REQ-034 req1 1234/0 -> no div_start; resp1 quot=0xFFFF, rem=1234, err=1 one cycle after accept.
REQ-035 div_done held low -> resp_valid with err=1, quot=0, rem=0 exactly TIMEOUT cycles after WAIT entry; the next request is served normally.
REQ-036 rst pulsed low during WAIT, then div_done pulsed -> no resp_valid, busy=0, FSM in IDLE.
